// File: rtl/sky_pkg.sv
// Shared definitions for the sky colour mixer: phase encoding, dither
// threshold table, output colour width and the level-weighted blend helper.
package sky_pkg;

    localparam int COLOR_W = 2;

    typedef enum logic [1:0] {
        PH_NIGHT = 2'd0,
        PH_DAWN  = 2'd1,
        PH_DAY   = 2'd2,
        PH_DUSK  = 2'd3
    } phase_t;

    // 4x4 ordered-dither thresholds, flat index is {y, x}
    localparam logic [0:15][3:0] BAYER = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // n + floor((d - n) * w / 256); w spans 0..256 so w=256 lands exactly on d
    function automatic logic [7:0] blendChannel(
        input logic [7:0] n,
        input logic [7:0] d,
        input logic [8:0] w
    );
        logic signed [17:0] diff;
        logic signed [17:0] prod;
        diff = $signed({10'b0, d}) - $signed({10'b0, n});
        prod = diff * $signed({9'b0, w});
        return 8'($signed({10'b0, n}) + (prod >>> 8));
    endfunction

endpackage

// File: rtl/dither_quant2.sv
// Combinational 8-bit to 2-bit quantiser with 4x4 ordered dithering.
module dither_quant2
    import sky_pkg::*;
(
    input  logic [7:0]         i_value,
    input  logic [1:0]         i_x,
    input  logic [1:0]         i_y,
    output logic [COLOR_W-1:0] o_q
);

    logic [5:0] w_pHi;
    logic [1:0] w_base;
    logic [3:0] w_frac;
    logic [3:0] w_thresh;
    logic       w_bump;

    // 3*v spreads 0..255 over 0..765; top two bits give the level, next four the fraction
    assign w_pHi    = 6'(({2'b00, i_value} + {1'b0, i_value, 1'b0}) >> 4);
    assign w_base   = w_pHi[5:4];
    assign w_frac   = w_pHi[3:0];
    assign w_thresh = BAYER[{i_y, i_x}];
    assign w_bump   = (w_frac > w_thresh);

    always_comb begin
        o_q = w_base + {1'b0, w_bump};
        if (i_value == 8'hFF) begin
            o_q = 2'd3;
        end
    end

endmodule

// File: rtl/sky_color_mixer.sv
// Per-frame sky colour: latches the fade level/direction, blends night to day,
// tints dawn/dusk and emits registered, dithered 2-bit RGB.
module sky_color_mixer
    import sky_pkg::*;
#(
    parameter logic [7:0] NIGHT_R = 8'd0,
    parameter logic [7:0] NIGHT_G = 8'd0,
    parameter logic [7:0] NIGHT_B = 8'd128,
    parameter logic [7:0] DAY_R   = 8'd0,
    parameter logic [7:0] DAY_G   = 8'd170,
    parameter logic [7:0] DAY_B   = 8'd255,
    parameter logic [7:0] LO_TH   = 8'd64,
    parameter logic [7:0] HI_TH   = 8'd192,
    parameter logic [7:0] TINT_R  = 8'd64,
    parameter logic [7:0] TINT_B  = 8'd32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_fade_level,
    input  logic               i_direction,
    input  logic               i_frame_start,
    input  logic               i_video_active,
    input  logic [1:0]         i_pix_x,
    input  logic [1:0]         i_pix_y,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic [1:0]         o_phase
);

    logic [7:0]         r_levelQ;
    logic               r_dirQ;
    logic               r_mixPending;
    logic [7:0]         r_mixR;
    logic [7:0]         r_mixG;
    logic [7:0]         r_mixB;
    phase_t             r_phase;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    logic [8:0]         w_weight;
    logic [7:0]         w_blendR;
    logic [7:0]         w_blendG;
    logic [7:0]         w_blendB;
    logic [8:0]         w_sumR;
    phase_t             w_nextPhase;
    logic               w_tinted;
    logic [7:0]         w_nextR;
    logic [7:0]         w_nextB;
    logic [COLOR_W-1:0] w_qR;
    logic [COLOR_W-1:0] w_qG;
    logic [COLOR_W-1:0] w_qB;

    // Level 255 must map to the full weight 256 so the day colour is reached exactly
    assign w_weight = {1'b0, r_levelQ} + {8'b0, r_levelQ[7]};
    assign w_blendR = blendChannel(NIGHT_R, DAY_R, w_weight);
    assign w_blendG = blendChannel(NIGHT_G, DAY_G, w_weight);
    assign w_blendB = blendChannel(NIGHT_B, DAY_B, w_weight);

    always_comb begin
        w_nextPhase = PH_NIGHT;
        if (r_levelQ >= HI_TH) begin
            w_nextPhase = PH_DAY;
        end else if (r_levelQ >= LO_TH) begin
            w_nextPhase = r_dirQ ? PH_DUSK : PH_DAWN;
        end
    end

    assign w_tinted = (w_nextPhase == PH_DAWN) || (w_nextPhase == PH_DUSK);
    assign w_sumR   = {1'b0, w_blendR} + {1'b0, TINT_R};

    always_comb begin
        w_nextR = w_blendR;
        w_nextB = w_blendB;
        if (w_tinted) begin
            w_nextR = w_sumR[8] ? 8'hFF : w_sumR[7:0];
            w_nextB = (w_blendB > TINT_B) ? (w_blendB - TINT_B) : 8'd0;
        end
    end

    // Latch on frame_start; the mix follows one edge later from the latched values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_levelQ     <= 8'd0;
            r_dirQ       <= 1'b0;
            r_mixPending <= 1'b0;
            r_mixR       <= NIGHT_R;
            r_mixG       <= NIGHT_G;
            r_mixB       <= NIGHT_B;
            r_phase      <= PH_NIGHT;
        end else begin
            if (r_mixPending) begin
                r_mixR       <= w_nextR;
                r_mixG       <= w_blendG;
                r_mixB       <= w_nextB;
                r_phase      <= w_nextPhase;
                r_mixPending <= 1'b0;
            end
            if (i_frame_start) begin
                r_levelQ     <= i_fade_level;
                r_dirQ       <= i_direction;
                r_mixPending <= 1'b1;
            end
        end
    end

    dither_quant2 u_quantR (
        .i_value (r_mixR),
        .i_x     (i_pix_x),
        .i_y     (i_pix_y),
        .o_q     (w_qR)
    );

    dither_quant2 u_quantG (
        .i_value (r_mixG),
        .i_x     (i_pix_x),
        .i_y     (i_pix_y),
        .o_q     (w_qG)
    );

    dither_quant2 u_quantB (
        .i_value (r_mixB),
        .i_x     (i_pix_x),
        .i_y     (i_pix_y),
        .o_q     (w_qB)
    );

    // Blanking forces black; visible pixels take the dithered mix
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (i_video_active) begin
            r_r <= w_qR;
            r_g <= w_qG;
            r_b <= w_qB;
        end else begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end
    end

    assign o_r     = r_r;
    assign o_g     = r_g;
    assign o_b     = r_b;
    assign o_phase = r_phase;

endmodule

// File: tb/tb_sky_color_mixer.sv
// Randomised self-checking bench for sky_color_mixer against an arithmetic
// model of the phase, blend, tint and dither rules.
module tb_sky_color_mixer;

    logic       clk;
    logic       rst;
    logic [7:0] fadeLevel;
    logic       direction;
    logic       frameStart;
    logic       videoActive;
    logic [1:0] pixX;
    logic [1:0] pixY;
    logic [1:0] outR;
    logic [1:0] outG;
    logic [1:0] outB;
    logic [1:0] outPhase;

    int compareCount  = 0;
    int mismatchCount = 0;

    int nightC[3] = '{0, 0, 128};
    int dayC[3]   = '{0, 170, 255};
    int bayerTab[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int edgeLevels[10] = '{0, 63, 64, 127, 128, 191, 192, 254, 255, 1};

    int mLevel;
    int mDir;
    int mPending;
    int mPhase;
    int mMix[3];
    int expR;
    int expG;
    int expB;

    sky_color_mixer dut (
        .clk            (clk),
        .rst            (rst),
        .i_fade_level   (fadeLevel),
        .i_direction    (direction),
        .i_frame_start  (frameStart),
        .i_video_active (videoActive),
        .i_pix_x        (pixX),
        .i_pix_y        (pixY),
        .o_r            (outR),
        .o_g            (outG),
        .o_b            (outB),
        .o_phase        (outPhase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor division of a possibly negative product by 256
    function automatic int blendModel(int n, int d, int lvl);
        int w;
        int prod;
        w = lvl + ((lvl >= 128) ? 1 : 0);
        prod = (d - n) * w;
        if (prod >= 0) return n + prod / 256;
        return n - ((-prod + 255) / 256);
    endfunction

    function automatic int quantModel(int v, int x, int y);
        int base;
        int frac;
        if (v == 255) return 3;
        base = (3 * v) / 256;
        frac = ((3 * v) % 256) / 16;
        return base + ((frac > bayerTab[y][x]) ? 1 : 0);
    endfunction

    task automatic resetModel();
        mLevel   = 0;
        mDir     = 0;
        mPending = 0;
        mPhase   = 0;
        for (int c = 0; c < 3; c++) mMix[c] = nightC[c];
        expR = 0;
        expG = 0;
        expB = 0;
    endtask

    task automatic recomputeMix();
        if (mLevel < 64) mPhase = 0;
        else if (mLevel >= 192) mPhase = 2;
        else mPhase = (mDir != 0) ? 3 : 1;
        for (int c = 0; c < 3; c++) mMix[c] = blendModel(nightC[c], dayC[c], mLevel);
        if (mPhase == 1 || mPhase == 3) begin
            mMix[0] = (mMix[0] + 64 > 255) ? 255 : mMix[0] + 64;
            mMix[2] = (mMix[2] - 32 < 0) ? 0 : mMix[2] - 32;
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check
    task automatic applyStimulus(input int lvl, input int dir, input int fs, input int va,
                                 input int x, input int y);
        @(negedge clk);
        fadeLevel   = 8'(lvl);
        direction   = 1'(dir);
        frameStart  = 1'(fs);
        videoActive = 1'(va);
        pixX        = 2'(x);
        pixY        = 2'(y);
        @(posedge clk);
        if (va != 0) begin
            expR = quantModel(mMix[0], x, y);
            expG = quantModel(mMix[1], x, y);
            expB = quantModel(mMix[2], x, y);
        end else begin
            expR = 0;
            expG = 0;
            expB = 0;
        end
        if (mPending != 0) begin
            recomputeMix();
            mPending = 0;
        end
        if (fs != 0) begin
            mLevel   = lvl;
            mDir     = dir;
            mPending = 1;
        end
        #1;
        checkOutput("red", int'(outR), expR);
        checkOutput("green", int'(outG), expG);
        checkOutput("blue", int'(outB), expB);
        checkOutput("phase", int'(outPhase), mPhase);
    endtask

    task automatic pixelSweep(input int lvl, input int dir);
        for (int i = 0; i < 16; i++) applyStimulus(lvl, dir, 0, 1, i % 4, i / 4);
    endtask

    task automatic asyncReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_red", int'(outR), 0);
        checkOutput("rst_green", int'(outG), 0);
        checkOutput("rst_blue", int'(outB), 0);
        checkOutput("rst_phase", int'(outPhase), 0);
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lvl;
        rst         = 1'b1;
        fadeLevel   = 8'd0;
        direction   = 1'b0;
        frameStart  = 1'b0;
        videoActive = 1'b0;
        pixX        = 2'd0;
        pixY        = 2'd0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("init_phase", int'(outPhase), 0);
        checkOutput("init_blue", int'(outB), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] night colours straight out of reset");
        pixelSweep(0, 0);

        $display("[TB] full day, then dawn and dusk at mid level");
        applyStimulus(255, 0, 1, 1, 0, 0);
        pixelSweep(0, 0);
        applyStimulus(128, 0, 1, 1, 1, 2);
        pixelSweep(0, 0);
        applyStimulus(128, 1, 1, 1, 3, 1);
        pixelSweep(0, 0);

        $display("[TB] level wanders with no frame_start");
        for (int i = 0; i < 1000; i++)
            applyStimulus($urandom_range(255), $urandom_range(1), 0, 1,
                          $urandom_range(3), $urandom_range(3));

        $display("[TB] blanking on and off");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 0, 0, i % 2, $urandom_range(3), $urandom_range(3));

        $display("[TB] randomised frames with boundary levels");
        for (int i = 0; i < 2000; i++) begin
            lvl = ($urandom_range(2) == 0) ? edgeLevels[$urandom_range(9)] : $urandom_range(255);
            applyStimulus(lvl, $urandom_range(1), ($urandom_range(11) == 0) ? 1 : 0,
                          ($urandom_range(7) == 0) ? 0 : 1, $urandom_range(3), $urandom_range(3));
        end

        $display("[TB] asynchronous reset with full day latched");
        applyStimulus(255, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 2, 2);
        asyncReset();
        pixelSweep(0, 0);

        for (int i = 0; i < 500; i++) begin
            lvl = ($urandom_range(2) == 0) ? edgeLevels[$urandom_range(9)] : $urandom_range(255);
            applyStimulus(lvl, $urandom_range(1), ($urandom_range(5) == 0) ? 1 : 0,
                          ($urandom_range(7) == 0) ? 0 : 1, $urandom_range(3), $urandom_range(3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
